airfryer_controller: RTL and testbench
======================================

// Module: airfryer_controller
// PURPOSE
//  Cook-cycle controller for the air-fryer demo. It conditions the board pushbuttons,
//  holds a user-set cook time and runs a 1 Hz countdown. It produces the start (cooking)
//  and done levels that the VGA display stage consumes to colour the window and indicators.
//  It sits directly upstream of the display, in the 100 MHz board clock domain.
// PARAMETERS
//  CLK_FREQ_HZ      100_000_000  clk cycles per 1 s tick; benches use a small value
//  DEBOUNCE_CYCLES  1_000_000    cycles a synchronized button must stay stable to be accepted
//  DEFAULT_TIME_S   10           cook time loaded at reset; legal range 1..MAX_TIME_S
//  MAX_TIME_S       99           upper saturation for the set time (fits in 7 bits)
//  DONE_HOLD_S      5            seconds the done indication holds before auto-return to idle
// PORTS
//  clk        in   1  board clock, 100 MHz
//  rst_n      in   1  asynchronous reset, active-low
//  btn_start  in   1  raw pushbutton, asynchronous, active-high
//  btn_cancel in   1  raw pushbutton, asynchronous, active-high
//  btn_up     in   1  raw pushbutton, adds 1 s to the set time
//  btn_down   in   1  raw pushbutton, subtracts 1 s from the set time
//  start      out  1  high while cooking (registered); drives the display's start input
//  done       out  1  high while in DONE (registered); drives the display's done input
//  time_left  out  7  remaining seconds while cooking; set time otherwise (registered)
//  sec_tick   out  1  one-cycle pulse on each 1 s tick in COOK or DONE
// BEHAVIOUR
//  - Reset (async on rst_n low): state=IDLE, set_time=time_left=DEFAULT_TIME_S,
//    start=0, done=0, sec_tick=0, prescaler=0, all conditioners cleared.
//  - Buttons: 2-FF sync, then a debounce counter, then a rising-edge detector. The result is a
//    1-cycle pulse. It fires DEBOUNCE_CYCLES+3 cycles after a clean press edge, with one pulse
//    per press. A release glitch shorter than DEBOUNCE_CYCLES produces no pulse.
//  - Prescaler: 0..CLK_FREQ_HZ-1, wraps. sec_tick fires on wrap. It runs only in COOK/DONE.
//    It is cleared to 0 on every entry into COOK and DONE, so the first tick arrives exactly
//    CLK_FREQ_HZ cycles after entry.
//  - FSM states {IDLE, COOK, DONE}:
//    IDLE: up -> set_time+1, saturating at MAX_TIME_S. down -> set_time-1, saturating at 1.
//      up and down in the same cycle -> no change. time_left tracks set_time.
//      start pulse -> COOK, with time_left<=set_time.
//    COOK: tick with time_left>1 -> time_left-1. tick with time_left==1 -> time_left=0 and go to DONE.
//      cancel -> IDLE, time_left<=set_time. start/up/down pulses are ignored.
//    DONE: time_left=0. It counts DONE_HOLD_S ticks, then goes to IDLE. A start or cancel pulse
//      goes to IDLE immediately (acknowledge). In IDLE, time_left<=set_time and set_time is
//      retained across cycles.
//  - Priority within a cycle: cancel > tick > start; an acknowledge in DONE beats the hold expiry.
//  - Outputs are registered from next-state: start/done change 1 cycle after the causing pulse/tick.
//    start and done are never both 1.
//  - The display samples start/done in its 25 MHz divided-clock domain. The levels are
//    quasi-static (>=1 s), so no handshake is needed.
//  - Async reset mid-cook aborts immediately to the reset values. There is no resume.
// STRUCTURE
//  - Shared package/header airfryer_pkg: state encoding (IDLE=2'd0, COOK=2'd1, DONE=2'd2),
//    TIME_W=7, MAX_TIME_S, DEFAULT_TIME_S.
//  - One sub-module, btn_conditioner (sync + debounce + edge), instantiated 4x.
//  - The FSM, prescaler, set-time register and countdown live in this module.
// TESTING  (CLK_FREQ_HZ=10, DEBOUNCE_CYCLES=2, DEFAULT_TIME_S=3, DONE_HOLD_S=2)
//  1 Reset: hold rst_n=0 -> start=0, done=0, time_left=3. Release; idle 50 cycles -> outputs unchanged.
//  2 Full cycle: press start -> start=1 at edge+6; time_left 3->2->1 every 10 cycles; at the
//    third tick start=0, done=1, time_left=0; 20 cycles later done=0, time_left=3.
//  3 Cancel: start, then cancel after 1 tick (time_left=2) -> IDLE, start=0, time_left=3, no done.
//  4 Saturation: 100 up presses -> time_left=99. 120 down presses -> 1. up+down together -> unchanged.
//  5 Debounce: 1-cycle glitch on btn_start -> no pulse, stays IDLE. Held press -> exactly one COOK entry.
//  6 Ack/reset: in DONE press cancel -> done=0 next cycle. rst_n low mid-COOK -> immediate reset values.

Source files
------------

// File: rtl/airfryer_pkg.sv
// Shared definitions for the air-fryer cook-cycle controller: state encoding,
// time-field width, default limits and the set-time adjust helper.
package airfryer_pkg;

  localparam int TIME_W         = 7;
  localparam int MAX_TIME_S     = 99;
  localparam int DEFAULT_TIME_S = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COOK = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One-second step of the set time, saturating at 1 and max_t; up+down cancel out.
  function automatic logic [TIME_W-1:0] adjust_time(input logic [TIME_W-1:0] cur,
                                                    input logic              up,
                                                    input logic              down,
                                                    input logic [TIME_W-1:0] max_t);
    logic [TIME_W-1:0] res;
    res = cur;
    if (up && !down && (cur < max_t))
      res = cur + TIME_W'(1);
    else if (down && !up && (cur > TIME_W'(1)))
      res = cur - TIME_W'(1);
    return res;
  endfunction

endpackage

// File: rtl/airfryer_controller_btn_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, stability debounce and a registered
// rising-edge detector producing one clk-wide pulse per accepted press.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync_meta;
  logic             sync_q;
  logic             stable;
  logic             stable_d;
  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      stable_d  <= 1'b0;
      cnt       <= '0;
      pulse     <= 1'b0;
    end else begin
      sync_meta <= btn;
      sync_q    <= sync_meta;
      // Any return to the accepted level restarts the stability window.
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync_q;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/airfryer_controller.sv
// Air-fryer cook-cycle controller: button conditioning, set-time register,
// 1 Hz countdown and the start/done levels consumed by the VGA display stage.
module airfryer_controller
  import airfryer_pkg::*;
#(
  parameter int CLK_FREQ_HZ     = 100_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int DEFAULT_TIME_S  = airfryer_pkg::DEFAULT_TIME_S,
  parameter int MAX_TIME_S      = airfryer_pkg::MAX_TIME_S,
  parameter int DONE_HOLD_S     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_start,
  input  logic              btn_cancel,
  input  logic              btn_up,
  input  logic              btn_down,
  output logic              start,
  output logic              done,
  output logic [TIME_W-1:0] time_left,
  output logic              sec_tick
);

  localparam int PRE_W  = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int HOLD_W = (DONE_HOLD_S > 1) ? $clog2(DONE_HOLD_S + 1) : 1;

  logic              start_p, cancel_p, up_p, down_p;
  logic [1:0]        state, state_n;
  logic [TIME_W-1:0] set_time, set_time_n, time_left_n;
  logic [HOLD_W-1:0] hold_cnt, hold_n;
  logic [PRE_W-1:0]  prescaler;
  logic              tick;

  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_start (
    .clk(clk), .rst_n(rst_n), .btn(btn_start), .pulse(start_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_cancel (
    .clk(clk), .rst_n(rst_n), .btn(btn_cancel), .pulse(cancel_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up), .pulse(up_p));
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cond_down (
    .clk(clk), .rst_n(rst_n), .btn(btn_down), .pulse(down_p));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n     = state;
    set_time_n  = set_time;
    time_left_n = time_left;
    hold_n      = hold_cnt;
    tick        = (state != ST_IDLE) && (prescaler == PRE_W'(CLK_FREQ_HZ - 1));

    case (state)
      ST_IDLE: begin
        if (start_p) begin
          state_n     = ST_COOK;
          time_left_n = set_time;
        end else begin
          set_time_n  = adjust_time(set_time, up_p, down_p, TIME_W'(MAX_TIME_S));
          time_left_n = set_time_n;
        end
      end
      ST_COOK: begin
        if (cancel_p) begin
          state_n     = ST_IDLE;
          time_left_n = set_time;
        end else if (tick) begin
          if (time_left > TIME_W'(1)) begin
            time_left_n = time_left - TIME_W'(1);
          end else begin
            time_left_n = '0;
            hold_n      = '0;
            state_n     = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        time_left_n = '0;
        // An acknowledge wins over the hold expiring in the same cycle.
        if (cancel_p || start_p) begin
          state_n     = ST_IDLE;
          time_left_n = set_time;
        end else if (tick) begin
          if (hold_cnt == HOLD_W'(DONE_HOLD_S - 1)) begin
            state_n     = ST_IDLE;
            time_left_n = set_time;
          end else begin
            hold_n = hold_cnt + HOLD_W'(1);
          end
        end
      end
      default: begin
        state_n     = ST_IDLE;
        time_left_n = set_time;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      set_time  <= TIME_W'(DEFAULT_TIME_S);
      time_left <= TIME_W'(DEFAULT_TIME_S);
      hold_cnt  <= '0;
      prescaler <= '0;
      start     <= 1'b0;
      done      <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_n;
      set_time  <= set_time_n;
      time_left <= time_left_n;
      hold_cnt  <= hold_n;
      // Clearing on every state change puts the first tick a full second after entry.
      if (state_n != state)
        prescaler <= '0;
      else if (state != ST_IDLE)
        prescaler <= tick ? '0 : prescaler + PRE_W'(1);
      start    <= (state_n == ST_COOK);
      done     <= (state_n == ST_DONE);
      sec_tick <= tick;
    end
  end

endmodule

// File: tb/tb_airfryer_controller.sv
// Self-checking bench for airfryer_controller: directed scenarios plus randomized
// set-time walks and cook cycles checked against a timeline model of the cook cycle.
module tb_airfryer_controller;

  localparam int F    = 10;  // clk cycles per second
  localparam int DB   = 2;   // debounce cycles
  localparam int DEF  = 3;
  localparam int H    = 2;   // done hold seconds
  localparam int MAXT = 99;
  localparam int LAT  = DB + 4;  // press edge -> registered output change

  localparam int B_START  = 0;
  localparam int B_CANCEL = 1;
  localparam int B_UP     = 2;
  localparam int B_DOWN   = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       btn_start = 1'b0, btn_cancel = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       start, done, sec_tick;
  logic [6:0] time_left;

  int n_tests = 0;
  int n_fail  = 0;
  int model_set;

  always #5 clk = ~clk;

  airfryer_controller #(
    .CLK_FREQ_HZ(F), .DEBOUNCE_CYCLES(DB), .DEFAULT_TIME_S(DEF),
    .MAX_TIME_S(MAXT), .DONE_HOLD_S(H)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_start(btn_start), .btn_cancel(btn_cancel), .btn_up(btn_up), .btn_down(btn_down),
    .start(start), .done(done), .time_left(time_left), .sec_tick(sec_tick)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      B_START:  btn_start  = v;
      B_CANCEL: btn_cancel = v;
      B_UP:     btn_up     = v;
      B_DOWN:   btn_down   = v;
      default:  ;
    endcase
  endtask

  // Clean press long enough to debounce; outputs have settled when it returns.
  task automatic tap(input int idx);
    set_btn(idx, 1'b1);
    step(4);
    set_btn(idx, 1'b0);
    step(6);
  endtask

  function automatic int model_adjust(input int cur, input int idx);
    if (idx == B_UP)   return (cur + 1 > MAXT) ? MAXT : cur + 1;
    if (idx == B_DOWN) return (cur - 1 < 1) ? 1 : cur - 1;
    return cur;
  endfunction

  task automatic set_time_to(input int target);
    while (model_set < target) begin tap(B_UP);   model_set = model_adjust(model_set, B_UP);   end
    while (model_set > target) begin tap(B_DOWN); model_set = model_adjust(model_set, B_DOWN); end
  endtask

  task automatic test_reset;
    logic [9:0] got;
    logic [9:0] exp;
    exp = {1'b0, 1'b0, 1'b0, 7'(DEF)};
    #1 rst_n = 1'b0;
    #1;
    got = {start, done, sec_tick, time_left};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_hold: {start,done,tick,tl}=%b want %b", got, exp);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    model_set = DEF;
    step(50);
    got = {start, done, sec_tick, time_left};
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL reset_idle50: {start,done,tick,tl}=%b want %b", got, exp);
    end
  endtask

  // Press start and follow the whole cook cycle cycle-by-cycle against the timeline:
  // COOK for T*F cycles counting down once per F, DONE for H*F cycles, then IDLE.
  // cx >= 0 schedules a cancel whose effect lands cx cycles after COOK entry.
  task automatic run_cook(input string name, input int t, input int cx);
    logic [8:0] got, exp;
    logic       e_tick;
    int         last;
    set_btn(B_START, 1'b1);
    for (int i = 1; i <= LAT; i++) begin
      step(1);
      if (i == 4) set_btn(B_START, 1'b0);
      if (i == LAT - 1) begin
        n_tests++;
        if (start !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_start_early: start=%b want 0 one cycle before latency", name, start);
        end
      end
    end
    last = (t + H) * F + 3;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) step(1);
      if (cx >= 0 && c >= cx)  exp = {1'b0, 1'b0, 7'(t)};
      else if (c < t * F)      exp = {1'b1, 1'b0, 7'(t - c / F)};
      else if (c < (t + H) * F) exp = {1'b0, 1'b1, 7'd0};
      else                     exp = {1'b0, 1'b0, 7'(t)};
      e_tick = (c > 0) && (c % F == 0) && (c / F <= t + H) && !(cx >= 0 && c >= cx);
      got = {start, done, time_left};
      n_tests++;
      if (got !== exp || sec_tick !== e_tick) begin
        n_fail++;
        $display("FAIL %s_c%0d: start=%b done=%b tl=%0d tick=%b want start=%b done=%b tl=%0d tick=%b",
                 name, c, start, done, time_left, sec_tick, exp[8], exp[7], exp[6:0], e_tick);
      end
      if (cx >= 0 && c == cx - LAT) set_btn(B_CANCEL, 1'b1);
      if (cx >= 0 && c == cx - LAT + 4) set_btn(B_CANCEL, 1'b0);
    end
    set_btn(B_CANCEL, 1'b0);
    step(10);
  endtask

  task automatic test_full_cycle;
    set_time_to(DEF);
    run_cook("full", DEF, -1);
  endtask

  task automatic test_cancel;
    set_time_to(DEF);
    run_cook("cancel", DEF, F + 8);
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 100; i++) begin
      tap(B_UP);
      model_set = model_adjust(model_set, B_UP);
      n_tests++;
      if (time_left !== 7'(model_set) || start !== 1'b0) begin
        n_fail++;
        $display("FAIL sat_up%0d: tl=%0d start=%b want tl=%0d start=0", i, time_left, start, model_set);
      end
    end
    for (int i = 0; i < 120; i++) begin
      tap(B_DOWN);
      model_set = model_adjust(model_set, B_DOWN);
      n_tests++;
      if (time_left !== 7'(model_set)) begin
        n_fail++;
        $display("FAIL sat_down%0d: tl=%0d want %0d", i, time_left, model_set);
      end
    end
    set_time_to(5);
    btn_up = 1'b1; btn_down = 1'b1;
    step(4);
    btn_up = 1'b0; btn_down = 1'b0;
    step(10);
    n_tests++;
    if (time_left !== 7'(model_set)) begin
      n_fail++;
      $display("FAIL up_down_together: tl=%0d want %0d", time_left, model_set);
    end
  endtask

  task automatic test_random_set;
    int idx;
    for (int i = 0; i < 25; i++) begin
      idx = $urandom_range(0, 1) ? B_UP : B_DOWN;
      tap(idx);
      model_set = model_adjust(model_set, idx);
      n_tests++;
      if (time_left !== 7'(model_set)) begin
        n_fail++;
        $display("FAIL rand_set%0d: tl=%0d want %0d", i, time_left, model_set);
      end
    end
  endtask

  task automatic test_random_cook;
    int t, cx;
    for (int k = 0; k < 5; k++) begin
      t = $urandom_range(1, 6);
      set_time_to(t);
      cx = $urandom_range(0, 1) ? int'($urandom_range(LAT + 1, (t + H) * F)) : -1;
      if (cx > 0 && cx % F == 0) cx++;
      run_cook($sformatf("rcook%0d", k), t, cx);
    end
  endtask

  task automatic test_debounce;
    int   rises;
    logic prev;
    set_time_to(1);
    btn_start = 1'b1;
    step(1);
    btn_start = 1'b0;
    step(15);
    n_tests++;
    if ({start, done, time_left} !== {1'b0, 1'b0, 7'd1}) begin
      n_fail++;
      $display("FAIL glitch: start=%b done=%b tl=%0d want 0 0 1", start, done, time_left);
    end
    rises = 0;
    prev  = start;
    btn_start = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (start && !prev) rises++;
      prev = start;
      if (i == 60) btn_start = 1'b0;
    end
    n_tests++;
    if (rises !== 1 || {start, done, time_left} !== {1'b0, 1'b0, 7'd1}) begin
      n_fail++;
      $display("FAIL held_press: cook entries=%0d start=%b done=%b tl=%0d want 1 entry, idle tl=1",
               rises, start, done, time_left);
    end
  endtask

  task automatic test_ack;
    int ack;
    set_time_to(2);
    for (int k = 0; k < 2; k++) begin
      ack = (k == 0) ? B_CANCEL : B_START;
      tap(B_START);
      step(2 * F - 10 + LAT);
      n_tests++;
      if ({start, done, time_left} !== {1'b0, 1'b1, 7'd0}) begin
        n_fail++;
        $display("FAIL ack%0d_in_done: start=%b done=%b tl=%0d want 0 1 0", k, start, done, time_left);
      end
      set_btn(ack, 1'b1);
      step(4);
      set_btn(ack, 1'b0);
      step(LAT - 5);
      n_tests++;
      if (done !== 1'b1) begin
        n_fail++;
        $display("FAIL ack%0d_early: done=%b want 1", k, done);
      end
      step(1);
      n_tests++;
      if ({start, done, time_left} !== {1'b0, 1'b0, 7'(model_set)}) begin
        n_fail++;
        $display("FAIL ack%0d: start=%b done=%b tl=%0d want 0 0 %0d", k, start, done, time_left, model_set);
      end
      step(10);
    end
  endtask

  task automatic test_reset_mid_cook;
    set_time_to(5);
    tap(B_START);
    step(15 - 10 + LAT);
    n_tests++;
    if ({start, time_left} !== {1'b1, 7'd4}) begin
      n_fail++;
      $display("FAIL midcook_pre: start=%b tl=%0d want 1 4", start, time_left);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({start, done, sec_tick, time_left} !== {1'b0, 1'b0, 1'b0, 7'(DEF)}) begin
      n_fail++;
      $display("FAIL midcook_reset: start=%b done=%b tick=%b tl=%0d want 0 0 0 %0d",
               start, done, sec_tick, time_left, DEF);
    end
    step(2);
    rst_n = 1'b1;
    model_set = DEF;
    step(3 * F);
    n_tests++;
    if ({start, done, time_left} !== {1'b0, 1'b0, 7'(DEF)}) begin
      n_fail++;
      $display("FAIL midcook_no_resume: start=%b done=%b tl=%0d want 0 0 %0d", start, done, time_left, DEF);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_cycle();
    test_cancel();
    test_saturation();
    test_random_set();
    test_random_cook();
    test_debounce();
    test_ack();
    test_reset_mid_cook();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
